overlay_scheduler: RTL

Frame-synchronous controller for the video overlay path: tracks vertical timing from `fvht_i`, and once per frame advances the moving-square position around the active-picture perimeter and sequences the eye-blink eyelid height. Outputs are stable for a whole frame and change only on the frame tick, so the pixel-rate overlay mixer downstream can compare raster counters against them without tearing. Sits between the timing source and the overlay mixer, in the `cen_i` clock-enable domain.

---
 rtl/overlay_scheduler.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/overlay_scheduler.sv
// Frame-rate overlay controller: detects the rising edge of V, then once per
// frame walks a square around the active-picture perimeter and sequences the
// eyelid of an eye-blink animation. All outputs are registered and change only
// on the frame tick, so the pixel-rate mixer can use them for a whole frame.
module overlay_scheduler #(
  parameter int unsigned ACTIVE_W     = 1024,
  parameter int unsigned ACTIVE_H     = 768,
  parameter int unsigned SQUARE_SIZE  = 20,
  parameter int unsigned STEP         = 4,
  parameter int unsigned BLINK_PERIOD = 120,
  parameter int unsigned EYELID_MAX   = 100,
  parameter int unsigned EYELID_STEP  = 20,
  parameter int unsigned CLOSED_HOLD  = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       cen_i,
  input  logic [3:0] fvht_i,
  input  logic       enable_i,
  input  logic       blink_req_i,
  output logic       frame_tick_o,
  output logic [9:0] square_x_o,
  output logic [9:0] square_y_o,
  output logic [1:0] dir_o,
  output logic [7:0] eyelid_o,
  output logic       blink_busy_o
);

  localparam logic [10:0] XMAX    = 11'(ACTIVE_W - SQUARE_SIZE);
  localparam logic [10:0] YMAX    = 11'(ACTIVE_H - SQUARE_SIZE);
  localparam logic [10:0] MSTEP   = 11'(STEP);
  localparam logic [9:0]  XMAX10  = 10'(ACTIVE_W - SQUARE_SIZE);
  localparam logic [9:0]  YMAX10  = 10'(ACTIVE_H - SQUARE_SIZE);
  localparam logic [9:0]  MSTEP10 = 10'(STEP);
  localparam logic [15:0] EMAX    = 16'(EYELID_MAX);
  localparam logic [15:0] ESTEP   = 16'(EYELID_STEP);
  localparam logic [7:0]  EMAX8   = 8'(EYELID_MAX);
  localparam logic [7:0]  ESTEP8  = 8'(EYELID_STEP);

  localparam int unsigned CNT_W  = $clog2(BLINK_PERIOD + 1);
  localparam int unsigned HOLD_W = $clog2(CLOSED_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLOSED_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLOSING = 2'd1,
    S_CLOSED  = 2'd2,
    S_OPENING = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  logic              v_dly_q, v_dly_d;
  logic              tick_q, tick_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  dir_t              dir_q, dir_d;
  logic [7:0]        eyelid_q, eyelid_d;
  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              req_q, req_d;

  logic        rise;
  logic [10:0] x_ext, y_ext, x_inc, y_inc;
  logic [15:0] eye_ext, eye_sum;
  logic        unused_fvht;

  assign rise    = fvht_i[2] & ~v_dly_q;
  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {1'b0, y_q};
  assign x_inc   = x_ext + MSTEP;
  assign y_inc   = y_ext + MSTEP;
  assign eye_ext = {8'h00, eyelid_q};
  assign eye_sum = eye_ext + ESTEP;

  assign unused_fvht = ^{fvht_i[3], fvht_i[1:0]};

  // Next-state: tick detection, perimeter motion, blink sequencing, request latch
  always_comb begin
    v_dly_d     = v_dly_q;
    tick_d      = tick_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    eyelid_d    = eyelid_q;
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    req_d       = req_q;

    if (cen_i) begin
      v_dly_d = fvht_i[2];
      tick_d  = rise;

      if (rise && enable_i) begin
        unique case (dir_q)
          DIR_RIGHT: begin
            if (x_inc >= XMAX) begin
              x_d   = XMAX10;
              dir_d = DIR_DOWN;
            end else begin
              x_d = x_inc[9:0];
            end
          end
          DIR_DOWN: begin
            if (y_inc >= YMAX) begin
              y_d   = YMAX10;
              dir_d = DIR_LEFT;
            end else begin
              y_d = y_inc[9:0];
            end
          end
          DIR_LEFT: begin
            if (x_ext <= MSTEP) begin
              x_d   = '0;
              dir_d = DIR_UP;
            end else begin
              x_d = x_q - MSTEP10;
            end
          end
          DIR_UP: begin
            if (y_ext <= MSTEP) begin
              y_d   = '0;
              dir_d = DIR_RIGHT;
            end else begin
              y_d = y_q - MSTEP10;
            end
          end
          default: ;
        endcase

        unique case (state_q)
          S_IDLE: begin
            if (frame_cnt_q == CNT_LAST || req_q) begin
              state_d     = S_CLOSING;
              frame_cnt_d = '0;
              req_d       = 1'b0;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_ONE;
            end
          end
          S_CLOSING: begin
            eyelid_d = (eye_sum >= EMAX) ? EMAX8 : eye_sum[7:0];
            if (eyelid_d == EMAX8) begin
              state_d    = S_CLOSED;
              hold_cnt_d = '0;
            end
          end
          S_CLOSED: begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
            if (hold_cnt_q == HOLD_LAST) begin
              state_d = S_OPENING;
            end
          end
          S_OPENING: begin
            eyelid_d = (eye_ext > ESTEP) ? (eyelid_q - ESTEP8) : '0;
            if (eyelid_d == '0) begin
              state_d = S_IDLE;
            end
          end
          default: ;
        endcase
      end

      // Requests are only captured while idle and not already departing IDLE.
      if (state_q == S_IDLE && state_d == S_IDLE && blink_req_i) begin
        req_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State registers; v_dly resets high so a V already high at release is not a tick
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_dly_q     <= 1'b1;
      tick_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= DIR_RIGHT;
      eyelid_q    <= '0;
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      hold_cnt_q  <= '0;
      req_q       <= 1'b0;
    end else begin
      v_dly_q     <= v_dly_d;
      tick_q      <= tick_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      eyelid_q    <= eyelid_d;
      state_q     <= state_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      req_q       <= req_d;
    end
  end

  assign frame_tick_o = tick_q;
  assign square_x_o   = x_q;
  assign square_y_o   = y_q;
  assign dir_o        = dir_q;
  assign eyelid_o     = eyelid_q;
  assign blink_busy_o = busy_q;

endmodule
